cmatmul_sequencer: RTL

//  Sequences the complex matrix-multiply datapath C = A x B over the four operand memories (M1/M2 real+imag).

---
 rtl/cmatmul_sequencer_pkg.sv | 16 +
 rtl/cmm_addr_gen.sv | 58 +++++
 rtl/cmatmul_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cmatmul_sequencer_pkg.sv
// Shared definitions for the complex matrix-multiply sequencer.
// Holds the sequencer state encoding and the default operand address width.
// No ports; imported by cmm_addr_gen and cmatmul_sequencer.
package cmatmul_sequencer_pkg;

    // Default operand/result memory address width.
    localparam int CMM_ADDR_BITS = 7;

    typedef enum logic [1:0] {
        CMM_IDLE  = 2'd0,
        CMM_RUN   = 2'd1,
        CMM_DRAIN = 2'd2,
        CMM_DONE  = 2'd3
    } cmm_state_t;

endpackage

// File: rtl/cmm_addr_gen.sv
// Nested i (outer) / j / k (inner) loop counters producing the shared A/B read addresses.
// Latency: addresses are direct concatenations of registered counters; one step per enabled cycle.
// Backpressure: i_en low holds every counter; the final (N-1,N-1,N-1) point is held, never wrapped.
// Ports: i_clk/i_rst clock and sync reset, i_clr zeroes the counters for a new run, i_en advances,
//        o_dir_m1={i,k}, o_dir_m2={k,j}, o_idx={i,j}, o_first (k==0), o_last (k==N-1), o_end (last point).
module cmm_addr_gen
    import cmatmul_sequencer_pkg::*;
#(
    parameter int N         = 8,
    parameter int ADDR_BITS = CMM_ADDR_BITS
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clr,
    input  logic                 i_en,
    output logic [ADDR_BITS-1:0] o_dir_m1,
    output logic [ADDR_BITS-1:0] o_dir_m2,
    output logic [ADDR_BITS-1:0] o_idx,
    output logic                 o_first,
    output logic                 o_last,
    output logic                 o_end
);

    localparam int             LB   = $clog2(N);
    localparam logic [LB-1:0]  MAXV = LB'(N - 1);
    localparam logic [LB-1:0]  ONE  = LB'(1);

    logic [LB-1:0] r_i;
    logic [LB-1:0] r_j;
    logic [LB-1:0] r_k;

    assign o_first  = (r_k == '0);
    assign o_last   = (r_k == MAXV);
    assign o_end    = (r_i == MAXV) && (r_j == MAXV) && (r_k == MAXV);

    // N is a power of two, so row-major addresses are plain concatenations.
    assign o_dir_m1 = ADDR_BITS'({r_i, r_k});
    assign o_dir_m2 = ADDR_BITS'({r_k, r_j});
    assign o_idx    = ADDR_BITS'({r_i, r_j});

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (i_en && !o_end) begin
            // Counters wrap naturally at N; carries ripple k -> j -> i.
            r_k <= r_k + ONE;
            if (r_k == MAXV) begin
                r_j <= r_j + ONE;
                if (r_j == MAXV) begin
                    r_i <= r_i + ONE;
                end
            end
        end
    end

endmodule

// File: rtl/cmatmul_sequencer.sv
// Sequencer for C = A x B over complex operand memories: one A/B read issue per cycle, MAC control, result writes.
// Latency: first issue the cycle after start is accepted; N^3 issues; done pulses RD_LAT+2 cycles after the last issue.
// Backpressure: none by default; with CMM_HOLD_EN defined, hold freezes the sequencer and masks mac_en/res_we.
// Ports: src_clk, rst (sync, active high), start (sampled in IDLE), busy, done (1-cycle pulse),
//        Dir_M1/Dir_M2 A/B read addresses, mac_en/mac_clr MAC control, res_we/res_addr result write,
//        hold (present only when CMM_HOLD_EN is defined).
module cmatmul_sequencer
    import cmatmul_sequencer_pkg::*;
#(
    parameter int N         = 8,
    parameter int ADDR_BITS = CMM_ADDR_BITS,
    parameter int RD_LAT    = 1
) (
    input  logic                 src_clk,
    input  logic                 rst,
    input  logic                 start,
`ifdef CMM_HOLD_EN
    input  logic                 hold,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_BITS-1:0] Dir_M1,
    output logic [ADDR_BITS-1:0] Dir_M2,
    output logic                 mac_en,
    output logic                 mac_clr,
    output logic                 res_we,
    output logic [ADDR_BITS-1:0] res_addr
);

    // Drain covers the RD_LAT tag delay plus the result-write cycle.
    localparam logic [2:0] DRAIN_LAST = 3'(RD_LAT);

    cmm_state_t            r_state;
    logic                  r_busy;
    logic                  r_done;
    logic [2:0]            r_drain;

    // Issue tags delayed to line up with operand data arriving at the MAC.
    logic                  r_tag_vld   [RD_LAT];
    logic                  r_tag_first [RD_LAT];
    logic                  r_tag_last  [RD_LAT];
    logic [ADDR_BITS-1:0]  r_tag_idx   [RD_LAT];

    logic                  r_res_we;
    logic [ADDR_BITS-1:0]  r_res_addr;

    logic                  w_stall;
    logic                  w_issue;
    logic                  w_clr;
    logic                  w_first;
    logic                  w_last;
    logic                  w_end;
    logic [ADDR_BITS-1:0]  w_idx;

`ifdef CMM_HOLD_EN
    assign w_stall = hold;
`else
    assign w_stall = 1'b0;
`endif

    assign w_issue = (r_state == CMM_RUN) && !w_stall;
    assign w_clr   = (r_state == CMM_IDLE) && start && !w_stall;

    cmm_addr_gen #(
        .N         (N),
        .ADDR_BITS (ADDR_BITS)
    ) u_addr_gen (
        .i_clk    (src_clk),
        .i_rst    (rst),
        .i_clr    (w_clr),
        .i_en     (w_issue),
        .o_dir_m1 (Dir_M1),
        .o_dir_m2 (Dir_M2),
        .o_idx    (w_idx),
        .o_first  (w_first),
        .o_last   (w_last),
        .o_end    (w_end)
    );

    always_ff @(posedge src_clk) begin
        if (rst) begin
            r_state <= CMM_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_drain <= 3'd0;
        end else if (!w_stall) begin
            case (r_state)
                CMM_IDLE: begin
                    if (start) begin
                        r_state <= CMM_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                CMM_RUN: begin
                    // The final point is still issued in this cycle.
                    if (w_end) begin
                        r_state <= CMM_DRAIN;
                        r_drain <= 3'd0;
                    end
                end
                CMM_DRAIN: begin
                    if (r_drain == DRAIN_LAST) begin
                        r_state <= CMM_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain + 3'd1;
                    end
                end
                CMM_DONE: begin
                    r_state <= CMM_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= CMM_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge src_clk) begin
        if (rst) begin
            for (int s = 0; s < RD_LAT; s++) begin
                r_tag_vld[s]   <= 1'b0;
                r_tag_first[s] <= 1'b0;
                r_tag_last[s]  <= 1'b0;
                r_tag_idx[s]   <= '0;
            end
            r_res_we   <= 1'b0;
            r_res_addr <= '0;
        end else if (!w_stall) begin
            r_tag_vld[0]   <= w_issue;
            r_tag_first[0] <= w_first;
            r_tag_last[0]  <= w_last;
            r_tag_idx[0]   <= w_idx;
            for (int s = 1; s < RD_LAT; s++) begin
                r_tag_vld[s]   <= r_tag_vld[s-1];
                r_tag_first[s] <= r_tag_first[s-1];
                r_tag_last[s]  <= r_tag_last[s-1];
                r_tag_idx[s]   <= r_tag_idx[s-1];
            end
            // Write one cycle after the last term accumulates; the MAC is registered,
            // so this write sees the finished sum even if the next element clears now.
            r_res_we <= r_tag_vld[RD_LAT-1] && r_tag_last[RD_LAT-1];
            if (r_tag_vld[RD_LAT-1] && r_tag_last[RD_LAT-1]) begin
                r_res_addr <= r_tag_idx[RD_LAT-1];
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign res_addr = r_res_addr;
    // Masked while held so the frozen pipeline head is not consumed twice.
    assign mac_en   = r_tag_vld[RD_LAT-1] && !w_stall;
    assign mac_clr  = r_tag_vld[RD_LAT-1] && r_tag_first[RD_LAT-1] && !w_stall;
    assign res_we   = r_res_we && !w_stall;

endmodule
